// File: rtl/bcd_cnt_nco.sv
`default_nettype none
// ============================================================================
// Module      : bcd_cnt_nco
// Description : Multi-digit packed-BCD up/down counter stepped by an internal
//               clock-enable tick divider. It supports parallel load, clear and
//               wrap/carry reporting. Defining BCD_CNT_SAT_EN makes the count
//               saturate at its boundaries instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_cnt_nco #(
    parameter int                  DIGITS = 2,
    parameter logic [4*DIGITS-1:0] TOP    = 8'h59
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           i_nco_num,
    input  logic                  i_run,
    input  logic                  i_up,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_tick,
    output logic                  o_carry,
    output logic                  o_load_err
);

    localparam int W = 4 * DIGITS;

`ifdef BCD_CNT_SAT_EN
    localparam logic c_SAT_EN = 1'b1;
`else
    localparam logic c_SAT_EN = 1'b0;
`endif

    logic [31:0]   div_q,  div_d;
    logic          tick_q, tick_d;
    logic [W-1:0]  bcd_q,  bcd_d;
    logic          carry_q, carry_d;
    logic          err_q,  err_d;

    logic [W-1:0]  w_inc;
    logic [W-1:0]  w_dec;
    logic [DIGITS:0] w_all9;
    logic [DIGITS:0] w_all0;
    logic [DIGITS-1:0] w_nib_ok;
    logic [31:0]   w_term;
    logic          w_load_ok;
    logic          w_at_top;
    logic          w_at_zero;

    assign w_all9[0] = 1'b1;
    assign w_all0[0] = 1'b1;

    // A digit moves only when every lower digit is rolling over.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [3:0] w_d;
            assign w_d          = bcd_q[4*g +: 4];
            assign w_all9[g+1]  = w_all9[g] & (w_d == 4'd9);
            assign w_all0[g+1]  = w_all0[g] & (w_d == 4'd0);
            assign w_inc[4*g +: 4] = !w_all9[g] ? w_d :
                                     ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1);
            assign w_dec[4*g +: 4] = !w_all0[g] ? w_d :
                                     ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
            assign w_nib_ok[g]  = (i_load_val[4*g +: 4] <= 4'd9);
        end
    endgenerate

    // With all nibbles legal, packed-BCD ordering equals binary ordering.
    assign w_load_ok = (&w_nib_ok) && (i_load_val <= TOP);
    assign w_term    = (i_nco_num <= 32'd1) ? 32'd0 : (i_nco_num - 32'd1);
    assign w_at_top  = (bcd_q == TOP);
    assign w_at_zero = (bcd_q == '0);

    always_comb begin
        div_d   = div_q;
        tick_d  = 1'b0;
        bcd_d   = bcd_q;
        carry_d = 1'b0;
        err_d   = 1'b0;

        if (i_clr) begin
            div_d = 32'd0;
            bcd_d = '0;
        end else if (i_load) begin
            if (w_load_ok) begin
                bcd_d = i_load_val;
                div_d = 32'd0;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            if (tick_q) begin
                if (i_up) begin
                    if (w_at_top) begin
                        bcd_d   = c_SAT_EN ? TOP : '0;
                        carry_d = 1'b1;
                    end else begin
                        bcd_d = w_inc;
                    end
                end else begin
                    if (w_at_zero) begin
                        bcd_d   = c_SAT_EN ? '0 : TOP;
                        carry_d = 1'b1;
                    end else begin
                        bcd_d = w_dec;
                    end
                end
            end
            // ">=" also catches a period shortened below the current phase.
            if (i_run) begin
                if (div_q >= w_term) begin
                    div_d  = 32'd0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 32'd0;
            tick_q  <= 1'b0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign o_bcd      = bcd_q;
    assign o_tick     = tick_q;
    assign o_carry    = carry_q;
    assign o_load_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_cnt_nco.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_cnt_nco
// Description : Scoreboard bench for bcd_cnt_nco using a decimal-integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_cnt_nco;

`ifdef BCD_CNT_SAT_EN
    localparam int          DIGITS = 3;
    localparam logic [11:0] TOP    = 12'h999;
    localparam bit          SAT    = 1'b1;
`else
    localparam int          DIGITS = 2;
    localparam logic [7:0]  TOP    = 8'h59;
    localparam bit          SAT    = 1'b0;
`endif
    localparam int W = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   nco = 32'd3;
    logic          run = 1'b0;
    logic          up = 1'b1;
    logic          clr = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  o_bcd;
    logic          o_tick, o_carry, o_load_err;

    bcd_cnt_nco #(.DIGITS(DIGITS), .TOP(TOP)) dut (
        .clk(clk), .rst_n(rst_n), .i_nco_num(nco), .i_run(run), .i_up(up),
        .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .o_bcd(o_bcd), .o_tick(o_tick), .o_carry(o_carry), .o_load_err(o_load_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] bcd;
        logic         tick;
        logic         carry;
        logic         err;
    } exp_t;

    exp_t   sb[$];
    int     tests_run = 0;
    int     failed    = 0;
    int     top_i;

    // Reference state: count kept as a plain decimal integer.
    int     m_cnt = 0;
    longint m_div = 0;
    bit     m_tick = 0, m_carry = 0, m_err = 0;

    function automatic int bcd2int(logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit load_legal(logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return bcd2int(v) <= top_i;
    endfunction

    task automatic model_edge();
        bit     old_tick;
        longint n;
        if (!rst_n || clr) begin
            m_cnt = 0; m_div = 0; m_tick = 0; m_carry = 0; m_err = 0;
        end else if (load) begin
            m_carry = 0;
            m_tick  = 0;
            if (load_legal(load_val)) begin
                m_cnt = bcd2int(load_val);
                m_div = 0;
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            old_tick = m_tick;
            m_carry  = 0;
            m_err    = 0;
            if (old_tick) begin
                if (up) begin
                    if (m_cnt == top_i) begin m_cnt = SAT ? top_i : 0; m_carry = 1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_cnt = SAT ? 0 : top_i; m_carry = 1; end
                    else m_cnt = m_cnt - 1;
                end
            end
            n = (nco == 32'd0) ? 64'd1 : longint'(nco);
            if (run) begin
                if (m_div >= n - 1) begin m_div = 0; m_tick = 1; end
                else begin m_div = m_div + 1; m_tick = 0; end
            end else begin
                m_tick = 0;
            end
        end
    endtask

    // Called at a falling edge with the inputs for the coming rising edge set.
    task automatic cycle(int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            model_edge();
            e.bcd   = int2bcd(m_cnt);
            e.tick  = m_tick;
            e.carry = m_carry;
            e.err   = m_err;
            sb.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {o_bcd, o_tick, o_carry, o_load_err};
                tests_run++;
                if (got !== e) begin
                    failed++;
                    $display("FAIL out_vec t=%0t bcd=%h tick=%b carry=%b err=%b expected bcd=%h tick=%b carry=%b err=%b",
                             $time, o_bcd, o_tick, o_carry, o_load_err, e.bcd, e.tick, e.carry, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        top_i = bcd2int(TOP);
        @(negedge clk);
        cycle(2);                                  // held in reset
        rst_n = 1'b1; nco = 32'd3; run = 1'b1; up = 1'b1;
        cycle(3 * (top_i + 1) + 12);               // full wrap at period 3

        up = 1'b0; nco = 32'd1;
        load = 1'b1; load_val = '0; cycle(1); load = 1'b0;
        cycle(16);                                 // 00 -> TOP -> ... borrow chain

        load = 1'b1;
        load_val = int2bcd(45); cycle(1);
        load_val = W'(8'h4A);   cycle(1);
        load_val = W'(8'h60);   cycle(1);
        load = 1'b0; cycle(2);
        load = 1'b1; clr = 1'b1; load_val = int2bcd(30); cycle(1);
        load = 1'b0; clr = 1'b0;

        up = 1'b1; nco = 32'd0; cycle(6);
        nco = 32'd1; cycle(6);
        run = 1'b0; cycle(5);
        run = 1'b1;

        nco = 32'd5;
        load = 1'b1; load_val = int2bcd(37); cycle(1); load = 1'b0;
        cycle(3);
        @(posedge clk); #3;
        rst_n = 1'b0;                              // mid-period, away from any edge
        #1;
        tests_run++;
        if ({o_bcd, o_tick, o_carry, o_load_err} !== '0) begin
            failed++;
            $display("FAIL async_reset bcd=%h tick=%b carry=%b err=%b expected all zero",
                     o_bcd, o_tick, o_carry, o_load_err);
        end
        @(negedge clk);
        cycle(1);
        rst_n = 1'b1;
        cycle(12);

        nco = 32'd1;
        load = 1'b1; load_val = TOP; cycle(1); load = 1'b0;
        up = 1'b1; cycle(4);
        load = 1'b1; load_val = '0; cycle(1); load = 1'b0;
        up = 1'b0; cycle(4);

        for (int i = 0; i < 2000; i++) begin
            nco      = 32'($urandom_range(0, 4));
            run      = ($urandom_range(0, 7) != 0);
            up       = $urandom_range(0, 1) != 0;
            clr      = ($urandom_range(0, 60) == 0);
            load     = ($urandom_range(0, 25) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 1) != 0) load_val = int2bcd($urandom_range(0, top_i));
            cycle(1);
        end
        clr = 1'b0; load = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            tests_run++;
            failed++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_cnt_nco.md
# bcd_cnt_nco

Parametrised multi-digit BCD up/down counter with a built-in single-clock-domain tick divider, parallel load, clear and wrap/carry reporting. It replaces the fixed 0~59 counter that runs on a divided clock: all state stays on `clk`, the step rate comes from a clock-enable tick, and the count is produced directly as packed BCD digits ready for the FND decoders and scan driver. Typical use is one instance per time field (seconds, minutes, hours), chained through `o_carry`.

## Interface
- `DIGITS`, default 2: number of BCD digits in the count.
- `TOP`, default 8'h59: terminal value, packed BCD, width 4*DIGITS. Every nibble must be 0..9; a non-BCD `TOP` is an illegal configuration.
- `clk` in 1: system clock (50 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `i_nco_num` in 32: tick period in `clk` cycles. Values 0 and 1 both mean a tick every cycle.
- `i_run` in 1: divider enable. When low, the divider holds.
- `i_up` in 1: direction. 1 counts up, 0 counts down. Sampled at the step edge.
- `i_clr` in 1: synchronous clear of the count and the divider.
- `i_load` in 1: synchronous parallel load request.
- `i_load_val` in 4*DIGITS: value to load, packed BCD. Digit 0 is in [3:0].
- `o_bcd` out 4*DIGITS: current count, packed BCD, registered.
- `o_tick` out 1: one-cycle pulse from the divider, registered.
- `o_carry` out 1: one-cycle pulse on wrap (or on a boundary hit; see Configuration), registered.
- `o_load_err` out 1: one-cycle pulse when a load is rejected, registered.

## Operation
- **Divider**
  - The 32-bit `div_cnt` increments on each edge where `i_run` is 1.
  - When `div_cnt` equals max(`i_nco_num`,1)−1, it returns to 0 and `o_tick` is 1 for the next cycle.
  - If `i_nco_num` changes mid-period, the new value is compared from the next edge. If `div_cnt` is already at or above the new terminal value, it returns to 0 and ticks.
- **Step**
  - At each edge where `o_tick` is 1, the count steps by one in the direction given by `i_up`.
  - A step is applied even if `i_run` has dropped in the meantime.
- **BCD arithmetic**
  - Digit 0 adds or subtracts 1. A digit carries into the next digit when it rolls 9→0 (up) or borrows when it rolls 0→9 (down).
  - Up at `TOP`: the count becomes all zeros and `o_carry` pulses.
  - Down at all zeros: the count becomes `TOP` and `o_carry` pulses.
  - A step never produces a value above `TOP`.
- **Priority per edge:** `i_clr` > `i_load` > step.
  - `i_clr`: `o_bcd`=0, `div_cnt`=0, `o_tick`=0. Any pending step is discarded.
  - `i_load`: accepted only if every nibble of `i_load_val` is ≤9 and the whole value is ≤`TOP`.
    - Accepted: `o_bcd`=`i_load_val`, `div_cnt`=0, and any pending step is discarded.
    - Rejected: `o_bcd` and the divider are unchanged, and `o_load_err` pulses for one cycle.
- **Reset values:** `o_bcd`=0, `o_tick`=0, `o_carry`=0, `o_load_err`=0, `div_cnt`=0.
  - Reset takes effect immediately on `rst_n` falling, including mid-period or with a pending tick.

## Timing
- With `i_run` held at 1 from reset release, `o_tick` is first high in the cycle after the N-th rising edge, where N=max(`i_nco_num`,1). After that, `o_tick` repeats every N cycles.
- `o_bcd` takes its new value one cycle after `o_tick`.
- `o_carry` is high in the same cycle as the wrapped `o_bcd` value.
- Load and clear have 1-cycle latency: the new `o_bcd` is visible the cycle after the request.
- Chaining: the next stage connects this stage's `o_carry` to a tick-enable path, so it steps one cycle after this stage's wrap.

## Configuration
- `BCD_CNT_SAT_EN` defined: the counter saturates instead of wrapping.
  - Up at `TOP` holds `TOP`; down at 0 holds 0.
  - `o_carry` still pulses for one cycle on each step attempted at the boundary, to flag overflow.
- `BCD_CNT_SAT_EN` undefined: wrap behaviour as described in Operation.

## Test plan
- Reset, `i_nco_num`=3, `i_run`=1, `i_up`=1, defaults: `o_tick` every 3 cycles; `o_bcd` steps 8'h00→8'h01→…→8'h09→8'h10→…→8'h59→8'h00; `o_carry` is high only with 8'h00.
- `i_up`=0 from 8'h00, `i_nco_num`=1: next values are 8'h59, 8'h58; `o_carry` is high with 8'h59; a borrow across 8'h50→8'h49 is checked.
- Load 8'h45: the next cycle shows `o_bcd`=8'h45 and `div_cnt` restarted. Load 8'h4A, then 8'h60: `o_bcd` is unchanged and `o_load_err` pulses once per request. `i_clr` together with `i_load` 8'h30 gives `o_bcd`=8'h00.
- `i_nco_num`=0, then 1: `o_tick` is high every cycle and `o_bcd` increments every cycle. `i_run`=0 freezes `o_tick` and the count.
- `rst_n` pulled low asynchronously mid-period at `o_bcd`=8'h37: all outputs are 0 before the next clock edge. After release, the first tick comes N cycles later.
- `DIGITS`=3, `TOP`=12'h999, `BCD_CNT_SAT_EN` defined, count at 12'h999, up tick: `o_bcd` stays 12'h999 and `o_carry` pulses. Down at 0 holds 0 and `o_carry` pulses.
